frame_burster: RTL
==================

FRAME_BURSTER -- requirements
Module: frame_burster

Interface
REQ-001 SHALL have parameter NO_CH, default 2, bits per sample.
REQ-002 SHALL have parameter LOG2_IMG_SIZE, default 10, log2 of samples per frame.
REQ-003 SHALL have parameter THROUGHPUT, default 1, samples per output beat; power of 2, at most 2^LOG2_IMG_SIZE.
REQ-004 SHALL have parameter GAP, default 2, idle cycles forced after each burst; at least 1.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port vld_in, input, 1, upstream sample valid.
REQ-008 SHALL have port rdy_in, output, 1, block can accept a sample; transfer occurs when vld_in && rdy_in.
REQ-009 SHALL have port data_in, input, NO_CH, one sample.
REQ-010 SHALL have port vld_out, output, 1, burst beat valid; no downstream backpressure.
REQ-011 SHALL have port data_out, output, unpacked array [THROUGHPUT-1:0] of NO_CH bits, beat lanes.
REQ-012 SHALL have port frames_sent, output, 16, count of completed bursts.

Function
REQ-013 SHALL buffer frames of N = 2^LOG2_IMG_SIZE samples in two banks (ping-pong), each with a full flag.
REQ-014 Write side SHALL store accepted samples in order into bank wr_bank at index wr_ptr; wr_ptr increments per transfer.
REQ-015 On the transfer with wr_ptr == N-1, SHALL set full[wr_bank], reset wr_ptr to 0 and toggle wr_bank, all at the same edge.
REQ-016 rdy_in SHALL equal !full[wr_bank], decoded only from registers (no combinational path from vld_in).
REQ-017 Read side SHALL be an FSM with states IDLE, BURST, GAP_WAIT.
REQ-018 IDLE -> BURST when full[rd_bank] is set; beat counter cleared.
REQ-019 In BURST, SHALL emit exactly B = N/THROUGHPUT consecutive beats with vld_out = 1 on every cycle; no gaps are permitted.
REQ-020 Beat b SHALL drive data_out[k] = sample (b*THROUGHPUT + THROUGHPUT-1-k); lane THROUGHPUT-1 carries the oldest sample.
REQ-021 After beat B-1, SHALL enter GAP_WAIT with vld_out = 0 for exactly GAP cycles.
REQ-022 On leaving GAP_WAIT, SHALL clear full[rd_bank], toggle rd_bank, increment frames_sent modulo 2^16, and return to IDLE.
REQ-023 vld_out and data_out SHALL be registered; data_out SHALL be all-zero whenever vld_out = 0.
REQ-024 Latency: if the read side is IDLE when the last sample of a frame is accepted at edge E, vld_out SHALL first be high after edge E+2.
REQ-025 Minimum frame-to-frame spacing SHALL be B + GAP + 1 cycles of vld_out pattern (B high, GAP+1 low), even when the next bank is already full.
REQ-026 Setting a full flag (write side) and clearing the other flag (read side) on the same edge SHALL both take effect.
REQ-027 If both banks are full, rdy_in SHALL be 0. An upstream vld_in without rdy_in SHALL be ignored and cause no state change.
REQ-028 rdy_in SHALL rise in the cycle after the edge that clears full[wr_bank].
REQ-029 Writing SHALL be possible into one bank while the other bank is read.

Reset
REQ-030 While rst is high at an edge: state IDLE, wr_ptr 0, wr_bank 0, rd_bank 0, both full flags 0, beat counter 0, frames_sent 0, vld_out 0, data_out all-zero.
REQ-031 rdy_in SHALL be 1 in the cycle after reset.
REQ-032 Reset mid-frame or mid-burst SHALL discard all buffered data; no partial burst may resume afterward.
REQ-033 Memory contents need not be cleared by reset.

Verification (LOG2_IMG_SIZE=4, NO_CH=2, GAP=2 unless noted)
REQ-034 Scenario 1: THROUGHPUT=1; 16 back-to-back samples 0,1,2,3,0,... -> vld_out high 16 consecutive cycles starting 2 edges after the last accept, data sequence identical, then 3 low cycles, frames_sent = 1.
REQ-035 Scenario 2: THROUGHPUT=4, samples s0..s15 = i mod 4 -> 4 beats; beat 0 data_out[3..0] = s0,s1,s2,s3.
REQ-036 Scenario 3: THROUGHPUT=1; 48 samples with vld_in always high -> rdy_in drops after 32 accepts until bank 0 is released; three bursts, each exactly 16 high cycles separated by 3 low cycles; frames_sent = 3.
REQ-037 Scenario 4: vld_in toggled randomly 50% -> burst is still 16 contiguous cycles; no vld_out during writing of frame 1.
REQ-038 Scenario 5: rst asserted on burst beat 7 -> vld_out 0 next cycle, frames_sent 0, rdy_in 1; a fresh 16-sample frame then bursts correctly.
REQ-039 Scenario 6: GAP=5, two full frames queued -> exactly 6 low cycles between bursts.

Source files
------------

// File: rtl/frame_burster.sv
// Ping-pong frame buffer: collects N-sample frames into two banks and replays
// each full bank as a gap-free burst of N/THROUGHPUT wide beats, followed by a forced idle gap.
module frame_burster #(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int THROUGHPUT    = 1,
    parameter int GAP           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    output logic             rdy_in,
    input  logic [NO_CH-1:0] data_in,
    output logic             vld_out,
    output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
    output logic [15:0]      frames_sent
);

    localparam int N     = 1 << LOG2_IMG_SIZE;
    localparam int BEATS = N / THROUGHPUT;
    localparam int AW    = LOG2_IMG_SIZE;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, BURST, GAP_WAIT} state_t;

    state_t            state, state_next;
    logic [NO_CH-1:0]  mem [2*N];
    logic [AW-1:0]     wr_ptr;
    logic              wr_bank, rd_bank;
    logic [1:0]        full;
    logic [AW-1:0]     beat_cnt, beat_next, beat_base;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic              release_bank;
    logic              vld_next;
    logic [NO_CH-1:0]  lanes_next [THROUGHPUT-1:0];
    logic              wr_fire, wr_last;

    // Ready depends only on registered flags, so there is no path from vld_in.
    assign rdy_in    = !full[wr_bank];
    assign wr_fire   = vld_in && rdy_in;
    assign wr_last   = wr_fire && (wr_ptr == AW'(N - 1));
    assign beat_base = AW'(int'(beat_cnt) * THROUGHPUT);

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wr_bank, wr_ptr}] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Set and clear always target different banks, so both may land on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (release_bank)
                full[rd_bank] <= 1'b0;
            if (wr_last)
                full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            vld_out     <= 1'b0;
            rd_bank     <= 1'b0;
            frames_sent <= '0;
            for (int k = 0; k < THROUGHPUT; k++)
                data_out[k] <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
            gap_cnt  <= gap_next;
            vld_out  <= vld_next;
            for (int k = 0; k < THROUGHPUT; k++)
                data_out[k] <= lanes_next[k];
            if (release_bank) begin
                rd_bank     <= ~rd_bank;
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

    // Lane THROUGHPUT-1 carries the oldest sample of each beat.
    always_comb begin
        state_next   = state;
        beat_next    = beat_cnt;
        gap_next     = gap_cnt;
        release_bank = 1'b0;
        vld_next     = 1'b0;
        for (int k = 0; k < THROUGHPUT; k++)
            lanes_next[k] = '0;

        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = BURST;
                    beat_next  = '0;
                end
            end
            BURST: begin
                vld_next = 1'b1;
                for (int k = 0; k < THROUGHPUT; k++)
                    lanes_next[k] = mem[{rd_bank, beat_base + AW'(THROUGHPUT - 1 - k)}];
                if (beat_cnt == AW'(BEATS - 1)) begin
                    state_next = GAP_WAIT;
                    gap_next   = '0;
                end else begin
                    beat_next = beat_cnt + 1'b1;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    state_next   = IDLE;
                    release_bank = 1'b1;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
